// File: rtl/gcd_rr_scheduler_if.sv
// Request/response and GCD-unit bus for the round-robin GCD scheduler.
// The slave modport is the scheduler's view. The master modport is the
// view of the environment, which is the requesters plus the GCD unit.
interface gcd_rr_scheduler_if #(
  parameter int NBits = 2,
  parameter int NReq  = 4
);
  logic [NReq-1:0]       req_i;
  logic [NReq*NBits-1:0] req_xi;
  logic [NReq*NBits-1:0] req_yi;
  logic [NReq-1:0]       grant_o;
  logic [NReq-1:0]       done_o;
  logic [NBits-1:0]      res_o;
  logic                  err_o;
  logic                  busy_o;
  logic                  gcd_start;
  logic [NBits-1:0]      gcd_xi;
  logic [NBits-1:0]      gcd_yi;
  logic [NBits-1:0]      gcd_xo;
  logic                  gcd_rdy;

  modport slave (
    input  req_i, req_xi, req_yi, gcd_xo, gcd_rdy,
    output grant_o, done_o, res_o, err_o, busy_o, gcd_start, gcd_xi, gcd_yi
  );

  modport master (
    output req_i, req_xi, req_yi, gcd_xo, gcd_rdy,
    input  grant_o, done_o, res_o, err_o, busy_o, gcd_start, gcd_xi, gcd_yi
  );
endinterface

// File: rtl/gcd_rr_scheduler.sv
// Round-robin scheduler that shares one GCD unit among NReq requesters.
// Requests with a zero operand are answered without using the unit.
// A watchdog aborts a WAIT that never sees a low-then-high rdy edge.
// Every output is a flop. Its next value is derived from the next FSM state,
// so grant and done line up with the cycle that the state occupies.
module gcd_rr_scheduler #(
  parameter int NBits         = 2,
  parameter int NReq          = 4,
  parameter int TimeoutCycles = 255
) (
  input  logic              clk,
  input  logic              rst,
  gcd_rr_scheduler_if.slave bus
);

  localparam int SW  = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int SW1 = SW + 1;
  localparam int CW  = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BYPASS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_low_q, seen_low_d;
  logic [NReq-1:0]  grant_q, grant_d;
  logic [NReq-1:0]  done_q, done_d;
  logic [NBits-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic [NBits-1:0] xi_q, xi_d;
  logic [NBits-1:0] yi_q, yi_d;

  // Unpack the flat operand buses into per-requester lanes.
  logic [NReq-1:0][NBits-1:0] x_arr;
  logic [NReq-1:0][NBits-1:0] y_arr;

  for (genvar k = 0; k < NReq; k++) begin : g_unpack
    assign x_arr[k] = bus.req_xi[k*NBits +: NBits];
    assign y_arr[k] = bus.req_yi[k*NBits +: NBits];
  end

  // Arbiter. Pick the first requester at or after ptr, searching upward and wrapping.
  logic [SW-1:0]  pick;
  logic           pick_vld;
  logic [SW1-1:0] sum;
  logic [SW-1:0]  idx;

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < NReq; i++) begin
      sum = {1'b0, ptr_q} + SW1'(i);
      if (sum >= SW1'(NReq)) sum = sum - SW1'(NReq);
      idx = sum[SW-1:0];
      if (!pick_vld && bus.req_i[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  // Next-state logic. Also updates the latched operands, result, pointer and watchdog.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    seen_low_d = seen_low_q;
    res_d      = res_q;
    err_d      = err_q;
    xi_d       = xi_q;
    yi_d       = yi_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          sel_d = pick;
          xi_d  = x_arr[pick];
          yi_d  = y_arr[pick];
          if (x_arr[pick] == '0 || y_arr[pick] == '0) state_d = S_BYPASS;
          else                                        state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Any rdy level seen while start is in flight belongs to the unit's
        // previous activity. Qualification therefore starts fresh in WAIT.
        seen_low_d = 1'b0;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_BYPASS: begin
        // gcd(0, v) = v and gcd(0, 0) is reported as 0. The OR yields both.
        res_d   = xi_q | yi_q;
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.gcd_rdy) seen_low_d = 1'b1;
        // rdy counts only if it is a rise after a low seen in this WAIT. A
        // stale high rdy left over from earlier work never completes a request.
        if (seen_low_q && bus.gcd_rdy) begin
          res_d   = bus.gcd_xo;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_d == CW'(TimeoutCycles)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = (sel_q == SW'(NReq - 1)) ? '0 : sel_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, decoded from the state being entered.
  always_comb begin
    grant_d = '0;
    done_d  = '0;
    start_d = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
    if (state_d == S_ISSUE || state_d == S_BYPASS) grant_d[sel_d] = 1'b1;
    if (state_d == S_DONE)                         done_d[sel_d]  = 1'b1;
  end

  // State and output registers, with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      xi_q       <= '0;
      yi_q       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      seen_low_q <= seen_low_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      res_q      <= res_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      xi_q       <= xi_d;
      yi_q       <= yi_d;
    end
  end

  assign bus.grant_o   = grant_q;
  assign bus.done_o    = done_q;
  assign bus.res_o     = res_q;
  assign bus.err_o     = err_q;
  assign bus.busy_o    = busy_q;
  assign bus.gcd_start = start_q;
  assign bus.gcd_xi    = xi_q;
  assign bus.gcd_yi    = yi_q;

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Bench for gcd_rr_scheduler with NBits=8, NReq=4 and TimeoutCycles=10.
// A behavioural GCD unit supports several modes: normal latency, stale rdy,
// and rdy stuck low. Expected completions go into a scoreboard queue when the
// requests are driven, and are popped when done_o fires.
module tb_gcd_rr_scheduler;

  localparam int M_NORM  = 0;
  localparam int M_STALE = 1;
  localparam int M_STUCK = 2;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] res;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   cyc_abs;
  int   mode;
  int   lat;
  exp_t sb[$];

  logic [3:0][7:0] tx;
  logic [3:0][7:0] ty;

  gcd_rr_scheduler_if #(.NBits(8), .NReq(4)) bus ();

  gcd_rr_scheduler #(.NBits(8), .NReq(4), .TimeoutCycles(10)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  assign bus.req_xi = tx;
  assign bus.req_yi = ty;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gcd8(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = b;
      b = a % b;
      a = t;
    end
    return a;
  endfunction

  // Behavioural GCD unit. It updates on the falling edge, so its outputs are stable at the rising edge.
  initial begin
    int cnt, sc;
    logic [7:0] lx, ly;
    cnt = 0; sc = 0; lx = 0; ly = 0;
    bus.gcd_rdy = 1'b1;
    bus.gcd_xo  = 8'd0;
    forever begin
      @(negedge clk);
      case (mode)
        M_NORM: begin
          if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
              bus.gcd_rdy = 1'b1;
              bus.gcd_xo  = gcd8(lx, ly);
            end
          end else if (bus.gcd_start) begin
            lx = bus.gcd_xi;
            ly = bus.gcd_yi;
            bus.gcd_rdy = 1'b0;
            cnt = lat;
          end
        end
        M_STALE: begin
          if (bus.gcd_start) begin
            sc = 1;
            bus.gcd_rdy = 1'b1;
            bus.gcd_xo  = 8'd99;
          end else if (sc > 0 && sc < 6) begin
            sc++;
            bus.gcd_rdy = (sc <= 3) || (sc == 6);
            if (sc == 6) bus.gcd_xo = 8'd7;
          end
        end
        default: begin
          if (bus.gcd_start) begin
            bus.gcd_rdy = 1'b0;
            cnt = 0;
          end
        end
      endcase
    end
  end

  // Invariant monitor: grant and done are one-hot, never overlap, and at most one request is in flight.
  initial begin
    int outstanding;
    outstanding = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) outstanding = 0;
      else if (bus.grant_o != 0 || bus.done_o != 0) begin
        n_cmp++;
        if ((bus.grant_o != 0 && bus.done_o != 0) || !$onehot0(bus.grant_o) ||
            !$onehot0(bus.done_o) || (bus.grant_o != 0 && outstanding != 0)) begin
          n_bad++;
          $display("FAIL handshake_invariant: grant=%b done=%b in_flight=%0d, want one-hot, exclusive, one in flight",
                   bus.grant_o, bus.done_o, outstanding);
        end
        if (bus.grant_o != 0) outstanding = 1;
        if (bus.done_o != 0)  outstanding = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc_abs++;
  endtask

  task automatic set_op(input logic [1:0] k, input logic [7:0] x, input logic [7:0] y);
    tx[k] = x;
    ty[k] = y;
  endtask

  task automatic wait_grant(input int maxc, output logic [3:0] g, output int c);
    g = 4'd0;
    c = 0;
    while (c < maxc) begin
      step();
      c++;
      if (bus.grant_o != 0) begin
        g = bus.grant_o;
        break;
      end
    end
  endtask

  task automatic wait_done(input int maxc, output logic [3:0] d, output logic [7:0] r,
                           output logic er, output int c);
    d = 4'd0; r = 8'd0; er = 1'b0; c = 0;
    while (c < maxc) begin
      step();
      c++;
      if (bus.done_o != 0) begin
        d  = bus.done_o;
        r  = bus.res_o;
        er = bus.err_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_i = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.grant_o, bus.done_o} !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_grant_done: got %b/%b want 0000/0000", bus.grant_o, bus.done_o);
    end
    n_cmp++;
    if ({bus.res_o, bus.err_o, bus.busy_o, bus.gcd_start, bus.gcd_xi, bus.gcd_yi} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: res=%h err=%b busy=%b start=%b xi=%h yi=%h want all 0",
               bus.res_o, bus.err_o, bus.busy_o, bus.gcd_start, bus.gcd_xi, bus.gcd_yi);
    end
    bus.req_i = 4'b0000;
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b want 0", bus.busy_o);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [3:0] g, d;
    logic [7:0] r;
    logic er;
    int c, last;
    mode = M_NORM; lat = 2;
    set_op(0, 12, 8); set_op(1, 9, 6); set_op(2, 35, 21); set_op(3, 16, 24);
    sb.push_back('{2'd0, 8'd4, 1'b0});
    sb.push_back('{2'd1, 8'd3, 1'b0});
    sb.push_back('{2'd2, 8'd7, 1'b0});
    sb.push_back('{2'd3, 8'd8, 1'b0});
    bus.req_i = 4'b1111;
    last = 0;
    for (int n = 0; n < 6; n++) begin
      if (n == 4) begin
        set_op(0, 10, 15); set_op(3, 14, 21);
        sb.push_back('{2'd0, 8'd5, 1'b0});
        sb.push_back('{2'd3, 8'd7, 1'b0});
        bus.req_i = 4'b1001;
      end
      wait_grant(20, g, c);
      e = sb[0];
      n_cmp++;
      if (g !== (4'b0001 << e.idx)) begin
        n_bad++;
        $display("FAIL rr_grant_order[%0d]: got %b want %b", n, g, 4'b0001 << e.idx);
      end
      if (n != 0 && n != 4) begin
        n_cmp++;
        if (cyc_abs - last !== 5) begin
          n_bad++;
          $display("FAIL rr_grant_spacing[%0d]: got %0d cycles want 5", n, cyc_abs - last);
        end
      end
      last = cyc_abs;
      bus.req_i[e.idx] = 1'b0;
      wait_done(20, d, r, er, c);
      e = sb.pop_front();
      n_cmp++;
      if (d !== (4'b0001 << e.idx) || r !== e.res || er !== e.err) begin
        n_bad++;
        $display("FAIL rr_done[%0d]: got done=%b res=%0d err=%b want done=%b res=%0d err=%b",
                 n, d, r, er, 4'b0001 << e.idx, e.res, e.err);
      end
    end
    step();
  endtask

  task automatic test_single();
    exp_t e;
    logic [3:0] g, d;
    logic [7:0] r;
    logic er;
    int c;
    mode = M_NORM; lat = 5;
    set_op(2, 12, 18);
    sb.push_back('{2'd2, 8'd6, 1'b0});
    bus.req_i = 4'b0100;
    wait_grant(4, g, c);
    n_cmp++;
    if (g !== 4'b0100 || c !== 1 || bus.gcd_start !== 1'b1) begin
      n_bad++;
      $display("FAIL single_grant: got grant=%b cycle=%0d start=%b want 0100 cycle 1 start 1", g, c, bus.gcd_start);
    end
    n_cmp++;
    if (bus.gcd_xi !== 8'd12 || bus.gcd_yi !== 8'd18) begin
      n_bad++;
      $display("FAIL single_operands: got %0d,%0d want 12,18", bus.gcd_xi, bus.gcd_yi);
    end
    bus.req_i = 4'b0000;
    wait_done(30, d, r, er, c);
    e = sb.pop_front();
    n_cmp++;
    if (d !== (4'b0001 << e.idx) || r !== e.res || er !== e.err || c + 1 !== 7) begin
      n_bad++;
      $display("FAIL single_done: got done=%b res=%0d err=%b cycle=%0d want %b %0d %b cycle 7",
               d, r, er, c + 1, 4'b0001 << e.idx, e.res, e.err);
    end
    n_cmp++;
    if (bus.gcd_xi !== 8'd12 || bus.gcd_yi !== 8'd18) begin
      n_bad++;
      $display("FAIL single_operand_hold: got %0d,%0d want 12,18", bus.gcd_xi, bus.gcd_yi);
    end
    step();
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 4'd0) begin
      n_bad++;
      $display("FAIL single_idle: busy=%b done=%b want 0 0000", bus.busy_o, bus.done_o);
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [1:0] bi [3] = '{2'd1, 2'd2, 2'd0};
    logic [7:0] bx [3] = '{8'd0, 8'd0, 8'd9};
    logic [7:0] by [3] = '{8'd25, 8'd0, 8'd0};
    logic [7:0] br [3] = '{8'd25, 8'd0, 8'd9};
    for (int n = 0; n < 3; n++) begin
      set_op(bi[n], bx[n], by[n]);
      sb.push_back('{bi[n], br[n], 1'b0});
      bus.req_i = 4'b0001 << bi[n];
      step();
      n_cmp++;
      if (bus.grant_o !== (4'b0001 << bi[n]) || bus.gcd_start !== 1'b0 || bus.busy_o !== 1'b1) begin
        n_bad++;
        $display("FAIL bypass_grant[%0d]: got grant=%b start=%b busy=%b want %b 0 1",
                 n, bus.grant_o, bus.gcd_start, bus.busy_o, 4'b0001 << bi[n]);
      end
      bus.req_i = 4'b0000;
      step();
      e = sb.pop_front();
      n_cmp++;
      if (bus.done_o !== (4'b0001 << e.idx) || bus.res_o !== e.res || bus.err_o !== e.err ||
          bus.gcd_start !== 1'b0) begin
        n_bad++;
        $display("FAIL bypass_done[%0d]: got done=%b res=%0d err=%b start=%b want %b %0d %b 0",
                 n, bus.done_o, bus.res_o, bus.err_o, bus.gcd_start, 4'b0001 << e.idx, e.res, e.err);
      end
      step();
      n_cmp++;
      if (bus.busy_o !== 1'b0 || bus.done_o !== 4'd0 || bus.gcd_start !== 1'b0) begin
        n_bad++;
        $display("FAIL bypass_idle[%0d]: busy=%b done=%b start=%b want 0", n, bus.busy_o, bus.done_o, bus.gcd_start);
      end
    end
  endtask

  task automatic test_stale_rdy();
    exp_t e;
    logic [3:0] g, d;
    logic [7:0] r;
    logic er;
    int c;
    mode = M_STALE;
    set_op(0, 21, 14);
    sb.push_back('{2'd0, 8'd7, 1'b0});
    bus.req_i = 4'b0001;
    wait_grant(4, g, c);
    n_cmp++;
    if (g !== 4'b0001) begin
      n_bad++;
      $display("FAIL stale_grant: got %b want 0001", g);
    end
    bus.req_i = 4'b0000;
    wait_done(30, d, r, er, c);
    e = sb.pop_front();
    n_cmp++;
    if (d !== (4'b0001 << e.idx) || r !== e.res || er !== e.err || c + 1 !== 7) begin
      n_bad++;
      $display("FAIL stale_done: got done=%b res=%0d err=%b cycle=%0d want %b %0d %b cycle 7",
               d, r, er, c + 1, 4'b0001 << e.idx, e.res, e.err);
    end
    step();
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [3:0] g, d;
    logic [7:0] r;
    logic er;
    int c;
    mode = M_STUCK;
    set_op(3, 5, 10);
    sb.push_back('{2'd3, 8'd0, 1'b1});
    bus.req_i = 4'b1000;
    wait_grant(4, g, c);
    n_cmp++;
    if (g !== 4'b1000) begin
      n_bad++;
      $display("FAIL timeout_grant: got %b want 1000", g);
    end
    bus.req_i = 4'b0000;
    set_op(1, 12, 8);
    sb.push_back('{2'd1, 8'd4, 1'b0});
    bus.req_i = 4'b0010;
    wait_done(30, d, r, er, c);
    e = sb.pop_front();
    n_cmp++;
    if (d !== (4'b0001 << e.idx) || r !== e.res || er !== e.err || c + 1 !== 12) begin
      n_bad++;
      $display("FAIL timeout_done: got done=%b res=%0d err=%b cycle=%0d want %b %0d %b cycle 12",
               d, r, er, c + 1, 4'b0001 << e.idx, e.res, e.err);
    end
    mode = M_NORM; lat = 3;
    wait_grant(6, g, c);
    n_cmp++;
    if (g !== 4'b0010) begin
      n_bad++;
      $display("FAIL timeout_next_grant: got %b want 0010", g);
    end
    bus.req_i = 4'b0000;
    wait_done(30, d, r, er, c);
    e = sb.pop_front();
    n_cmp++;
    if (d !== (4'b0001 << e.idx) || r !== e.res || er !== e.err) begin
      n_bad++;
      $display("FAIL timeout_next_done: got done=%b res=%0d err=%b want %b %0d %b",
               d, r, er, 4'b0001 << e.idx, e.res, e.err);
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    logic [3:0] g, d;
    logic [7:0] r;
    logic er;
    int c;
    mode = M_NORM; lat = 2;
    set_op(1, 6, 4);
    sb.push_back('{2'd1, 8'd2, 1'b0});
    bus.req_i = 4'b0010;
    wait_grant(4, g, c);
    bus.req_i = 4'b0000;
    wait_done(20, d, r, er, c);
    e = sb.pop_front();
    n_cmp++;
    if (g !== 4'b0010 || d !== (4'b0001 << e.idx) || r !== e.res || er !== e.err) begin
      n_bad++;
      $display("FAIL rstw_setup: got grant=%b done=%b res=%0d want 0010 %b %0d", g, d, r, 4'b0001 << e.idx, e.res);
    end
    step();
    mode = M_STUCK;
    set_op(2, 3, 6);
    bus.req_i = 4'b0100;
    wait_grant(4, g, c);
    set_op(1, 10, 4);
    set_op(3, 9, 12);
    bus.req_i = 4'b1010;
    repeat (3) step();
    n_cmp++;
    if (g !== 4'b0100 || bus.busy_o !== 1'b1 || bus.done_o !== 4'd0) begin
      n_bad++;
      $display("FAIL rstw_in_wait: got grant=%b busy=%b done=%b want 0100 1 0000", g, bus.busy_o, bus.done_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.grant_o, bus.done_o, bus.res_o, bus.err_o, bus.busy_o, bus.gcd_start,
         bus.gcd_xi, bus.gcd_yi} !== 35'd0) begin
      n_bad++;
      $display("FAIL rstw_async_clear: grant=%b done=%b res=%h err=%b busy=%b start=%b xi=%h yi=%h want all 0",
               bus.grant_o, bus.done_o, bus.res_o, bus.err_o, bus.busy_o, bus.gcd_start, bus.gcd_xi, bus.gcd_yi);
    end
    mode = M_NORM; lat = 2;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    sb.push_back('{2'd1, 8'd2, 1'b0});
    sb.push_back('{2'd3, 8'd3, 1'b0});
    for (int n = 0; n < 2; n++) begin
      wait_grant(10, g, c);
      e = sb[0];
      n_cmp++;
      if (g !== (4'b0001 << e.idx)) begin
        n_bad++;
        $display("FAIL rstw_grant[%0d]: got %b want %b", n, g, 4'b0001 << e.idx);
      end
      bus.req_i[e.idx] = 1'b0;
      wait_done(20, d, r, er, c);
      e = sb.pop_front();
      n_cmp++;
      if (d !== (4'b0001 << e.idx) || r !== e.res || er !== e.err) begin
        n_bad++;
        $display("FAIL rstw_done[%0d]: got done=%b res=%0d err=%b want %b %0d %b",
                 n, d, r, er, 4'b0001 << e.idx, e.res, e.err);
      end
    end
    step();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc_abs = 0;
    mode = M_NORM; lat = 2;
    rst_n = 1'b0;
    bus.req_i = 4'b0000;
    tx = '0;
    ty = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_bypass();
    test_stale_rdy();
    test_timeout();
    test_reset_mid_wait();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 time units, want finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/gcd_rr_scheduler.md
# gcd_rr_scheduler

Round-robin scheduler that shares one `pLib_gcd_rtl`-style GCD datapath between `NReq` requesters. It latches the winning requester's operands, sequences the unit's `start`/`rdy` handshake, and returns the result to that requester. A zero-operand bypass answers trivial requests without occupying the unit. A watchdog prevents a hung unit from stalling every requester.

## Interface
- `NBits`, 2, operand/result width
- `NReq`, 4, number of requesters (≥2)
- `TimeoutCycles`, 255, max WAIT cycles before abort (≥4)

- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req_i`  in  NReq  request level per requester, held until grant
- `req_xi`  in  NReq*NBits  operand x, requester k at [k*NBits +: NBits]
- `req_yi`  in  NReq*NBits  operand y, same packing
- `grant_o`  out  NReq  one-hot pulse: operands of requester k accepted
- `done_o`  out  NReq  one-hot pulse: result for requester k valid
- `res_o`  out  NBits  result, valid while any `done_o` bit is set
- `err_o`  out  1  timeout flag, valid with `done_o`
- `busy_o`  out  1  high in every state except IDLE
- `gcd_start`  out  1  one-cycle start to the GCD unit
- `gcd_xi`, `gcd_yi`  out  NBits  operands to the GCD unit, stable from ISSUE until return to IDLE
- `gcd_xo`  in  NBits  GCD unit result
- `gcd_rdy`  in  1  GCD unit ready/result-valid

## Operation
- States: IDLE, ISSUE, BYPASS, WAIT, DONE.
- IDLE:
  - If `req_i` is nonzero, select the first set bit at or after `ptr`, searching upward with wrap.
  - Latch that requester's operands into `gcd_xi`/`gcd_yi` and its index into `sel`.
  - If either operand is 0, go to BYPASS; otherwise go to ISSUE.
- ISSUE (1 cycle): `gcd_start`=1 and `grant_o[sel]`=1. Clear `seen_low` and the timeout counter. Go to WAIT.
- BYPASS (1 cycle): `grant_o[sel]`=1, `res_o` := `gcd_xi | gcd_yi` (0 when both are 0). Go to DONE.
- WAIT:
  - Increment the counter each cycle.
  - Set `seen_low` when `gcd_rdy`=0.
  - If `seen_low` is set and `gcd_rdy`=1: `res_o` := `gcd_xo`, `err_o`:=0, go to DONE.
  - Else if the counter reaches `TimeoutCycles`: `res_o`:=0, `err_o`:=1, go to DONE.
  - A stale high `gcd_rdy` before the unit drops it never completes a request.
- DONE (1 cycle): `done_o[sel]`=1, `ptr` := (`sel`+1) mod `NReq`, go to IDLE.
- Requester rule: deassert `req_i[k]`, or present new operands, no later than the edge after the `grant_o[k]` pulse. Requests are sampled only in IDLE.
- A `req_i` change outside IDLE has no effect. Operand changes after grant are ignored.
- After a timeout the GCD unit is not reset. The next ISSUE still requires `rdy` low-then-high.
- Reset (asynchronous, any state): FSM→IDLE; `ptr`, `sel`, counter, `seen_low` → 0; all outputs 0.

## Timing
- Reset values: `grant_o`, `done_o`, `res_o`, `err_o`, `busy_o`, `gcd_start`, `gcd_xi`, `gcd_yi` all 0.
- All outputs are registered. No combinational path from inputs to outputs.
- GCD path: request seen in IDLE at cycle 0 → ISSUE at cycle 1 → WAIT from cycle 2.
  - If the qualifying `rdy` rise is sampled at cycle t, DONE occurs at cycle t+1.
  - Earliest completion: `rdy` low at cycle 2, high at cycle 3, DONE at cycle 4.
  - Minimum spacing between grants: 5 cycles.
- Bypass path: IDLE cycle 0 → BYPASS cycle 1 (grant) → DONE cycle 2 → IDLE cycle 3.
- Timeout: DONE occurs at cycle 2+`TimeoutCycles` when no qualifying rise arrives.
- Simultaneous requests: exactly one grant. The others wait and are served in `ptr` order.
- `done_o` and `grant_o` are never high in the same cycle and never have more than one bit set.

## Test plan
- NBits=8, NReq=4. Single req k=2 with xi=12, yi=18; model unit returns 6 after 5 cycles → `grant_o`=0100 in cycle 1, `gcd_start` pulse in cycle 1, `done_o`=0100 with `res_o`=6 and `err_o`=0.
- All four request from reset → grants in order 0,1,2,3. Then req 0 and 3 re-request after `ptr`=0 → grant 0 before 3. Never two grants in flight.
- Bypass: xi=0, yi=25 → `res_o`=25; xi=0, yi=0 → `res_o`=0. Done 2 cycles after selection, `gcd_start` never asserted.
- Stale `rdy`: unit holds `rdy`=1 for 3 cycles after start, then low 2 cycles, then high with `xo`=7 → completion only on the late rise, `res_o`=7.
- Timeout (`TimeoutCycles`=10): `rdy` stuck low → `done_o[sel]`=1, `err_o`=1, `res_o`=0 at cycle 12. Next requester is served normally.
- `rst` pulsed low mid-WAIT → all outputs 0 immediately. After release, a pending req 1 is granted from `ptr`=0, so req 1 is granted first.
